// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requester blocks and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       valid;
  logic [7:0] hold_cnt;
  logic       timeout;

  modport master (
    output req,
    input  gnt, gnt_id, valid, hold_cnt, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_id, valid, hold_cnt, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant is held until the owner drops its request.
// Optional forced release after MAXHOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int unsigned MAXHOLD = 15
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [7:0] HOLD_LIMIT = 8'(MAXHOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] id_q, id_d;
  logic [7:0] hold_q, hold_d;
  logic       to_q, to_d;

  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;
  logic       force_rel;

  // First set request walking from ptr upward, wrapping mod 8.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign force_rel = TIMEOUT_ON && (hold_q == HOLD_LIMIT) && bus.req[id_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 8'b1 << winner;
          id_d    = winner;
          hold_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.req[id_q] || force_rel) begin
          // gnt_id keeps the last owner; the pointer moves past it so it goes to the back.
          gnt_d   = '0;
          hold_d  = '0;
          ptr_d   = id_q + 3'd1;
          to_d    = force_rel;
          state_d = IDLE;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = id_q;
  assign bus.valid    = |gnt_q;
  assign bus.hold_cnt = hold_q;
  assign bus.timeout  = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table plus generated sequences,
// with expected outputs queued at drive time and compared after each clock edge.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_MAXHOLD = 8;
`else
  localparam int unsigned TB_MAXHOLD = 15;
`endif

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic [7:0] hold;
    logic       to;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAXHOLD(TB_MAXHOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   seq_no = 0;

  function automatic vec_t v(input logic r, input logic [7:0] rq, input logic [7:0] g,
                             input logic [2:0] id, input logic vl, input logic [7:0] h,
                             input logic t);
    vec_t x;
    x.rst = r; x.req = rq; x.gnt = g; x.id = id; x.valid = vl; x.hold = h; x.to = t;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    @(negedge clk);
    rst     = x.rst;
    bus.req = x.req;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected record per clock edge, compared 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.gnt_id !== e.id || bus.valid !== e.valid ||
          bus.hold_cnt !== e.hold || bus.timeout !== e.to) begin
        errors++;
        $display("FAIL step%0d: got gnt=%h id=%0d valid=%b hold=%0d to=%b, expected gnt=%h id=%0d valid=%b hold=%0d to=%b",
                 seq_no, bus.gnt, bus.gnt_id, bus.valid, bus.hold_cnt, bus.timeout,
                 e.gnt, e.id, e.valid, e.hold, e.to);
      end
      seq_no++;
    end
  end

  vec_t tbl[28];

  initial begin
    bus.req = '0;

    //            rst  req     gnt     id   v     hold  to
    tbl[0]  = v(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0);
    tbl[1]  = v(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0);
    tbl[2]  = v(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 8'd0, 1'b0);
    tbl[3]  = v(1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 8'd1, 1'b0);
    tbl[4]  = v(1'b0, 8'h80, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0);
    tbl[5]  = v(1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 8'd0, 1'b0);
    tbl[6]  = v(1'b0, 8'h83, 8'h80, 3'd7, 1'b1, 8'd1, 1'b0);
    tbl[7]  = v(1'b0, 8'h03, 8'h00, 3'd7, 1'b0, 8'd0, 1'b0);
    tbl[8]  = v(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 8'd0, 1'b0);
    tbl[9]  = v(1'b0, 8'h02, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0);
    tbl[10] = v(1'b0, 8'h02, 8'h02, 3'd1, 1'b1, 8'd0, 1'b0);
    tbl[11] = v(1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 8'd0, 1'b0);
    tbl[12] = v(1'b0, 8'h00, 8'h00, 3'd1, 1'b0, 8'd0, 1'b0);
    tbl[13] = v(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 8'd0, 1'b0);
    tbl[14] = v(1'b0, 8'h01, 8'h00, 3'd2, 1'b0, 8'd0, 1'b0);
    tbl[15] = v(1'b0, 8'h05, 8'h01, 3'd0, 1'b1, 8'd0, 1'b0);
    tbl[16] = v(1'b0, 8'h04, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0);
    tbl[17] = v(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 8'd0, 1'b0);
    tbl[18] = v(1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 8'd0, 1'b0);
    tbl[19] = v(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd0, 1'b0);
    tbl[20] = v(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd1, 1'b0);
    tbl[21] = v(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd2, 1'b0);
    tbl[22] = v(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd3, 1'b0);
    tbl[23] = v(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd4, 1'b0);
    tbl[24] = v(1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 8'd5, 1'b0);
    tbl[25] = v(1'b1, 8'h30, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0);
    tbl[26] = v(1'b0, 8'h30, 8'h10, 3'd4, 1'b1, 8'd0, 1'b0);
    tbl[27] = v(1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 8'd0, 1'b0);

    foreach (tbl[i]) drive(tbl[i]);

    // Fairness: all requesting, each owner holds three cycles then drops for one.
    drive(v(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0));
    for (int k = 0; k < 9; k++) begin
      logic [2:0] id;
      logic [7:0] onehot;
      id     = 3'(k % 8);
      onehot = 8'b1 << id;
      drive(v(1'b0, 8'hFF, onehot, id, 1'b1, 8'd0, 1'b0));
      drive(v(1'b0, 8'hFF, onehot, id, 1'b1, 8'd1, 1'b0));
      drive(v(1'b0, 8'hFF, onehot, id, 1'b1, 8'd2, 1'b0));
      drive(v(1'b0, 8'hFF & ~onehot, 8'h00, id, 1'b0, 8'd0, 1'b0));
    end

`ifdef ARB_TIMEOUT_EN
    // Forced release after TB_MAXHOLD busy cycles, then re-grant or hand-over.
    drive(v(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0, 1'b0));
    for (int r = 0; r < 2; r++) begin
      drive(v(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 8'd0, 1'b0));
      for (int h = 1; h < int'(TB_MAXHOLD); h++)
        drive(v(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 8'(h), 1'b0));
      drive(v(1'b0, 8'h04, 8'h00, 3'd2, 1'b0, 8'd0, 1'b1));
    end
    drive(v(1'b0, 8'h0C, 8'h08, 3'd3, 1'b1, 8'd0, 1'b0));
    drive(v(1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 8'd0, 1'b0));
`else
    // Without the timeout a grant is held indefinitely and hold_cnt saturates.
    drive(v(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 8'd0, 1'b0));
    for (int h = 1; h < 300; h++)
      drive(v(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, (h > 255) ? 8'd255 : 8'(h), 1'b0));
    drive(v(1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 8'd0, 1'b0));
`endif

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending records, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
